// File: rtl/uart_pkg.sv
// Shared definitions for the MPU serial link: FSM encodings, frame header
// defaults and the sensor register map used by the command requesters.
package uart_pkg;

  localparam logic [7:0] S_IDLE  = 8'h00;
  localparam logic [7:0] S_HDR0  = 8'h01;
  localparam logic [7:0] S_HDR1  = 8'h02;
  localparam logic [7:0] S_ADDR  = 8'h03;
  localparam logic [7:0] S_DATAL = 8'h04;
  localparam logic [7:0] S_DATAH = 8'h05;
  localparam logic [7:0] S_GAP   = 8'h06;

  localparam logic [7:0] HDR0_DEF = 8'hFF;
  localparam logic [7:0] HDR1_DEF = 8'hAA;

  localparam logic [7:0]  REG_SAVE   = 8'h00;
  localparam logic [7:0]  REG_CALSW  = 8'h01;
  localparam logic [7:0]  REG_RRATE  = 8'h03;
  localparam logic [7:0]  REG_UNLOCK = 8'h69;
  localparam logic [15:0] UNLOCK_KEY = 16'hB588;

endpackage

// File: rtl/uart_rr_arb.sv
// Round-robin priority encoder: the first asserted request at or after
// rr_ptr (wrapping) wins. Purely combinational.
module uart_rr_arb #(
  parameter int NUM_REQ = 2,
  parameter int IW      = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IW-1:0]      gnt_idx,
  output logic               gnt_vld
);

  int          k;
  logic [IW-1:0] ki;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    k       = 0;
    ki      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(rr_ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      ki = IW'(k);
      if (!gnt_vld && req[ki]) begin
        gnt_vld     = 1'b1;
        gnt_idx     = ki;
        gnt_oh[ki]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_cmd_sched.sv
// Transmit-side command scheduler: arbitrates requesters onto one UART byte
// transmitter, sends a 5-byte config frame per grant, then holds off a gap.
module uart_cmd_sched
  import uart_pkg::*;
#(
  parameter int          NUM_REQ    = 2,
  parameter logic [15:0] GAP_CYCLES = 16'd1000,
  parameter logic [7:0]  HDR0       = HDR0_DEF,
  parameter logic [7:0]  HDR1       = HDR1_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [8*NUM_REQ-1:0]    req_addr,
  input  logic [16*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      ack,
  output logic [7:0]              tx_data,
  output logic                    tx_vld,
  input  logic                    tx_rdy,
  output logic                    busy,
  output logic [31:0]             reg_frame_num,
  input  logic                    reg_frame_clr,
  output logic [7:0]              dbg_state
);

  localparam int            IW   = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

  // Handshake: a byte moves on a cycle with tx_vld && tx_rdy; until then
  // tx_vld and tx_data hold, and tx_vld only falls after a transfer.
  logic [7:0]         state_q, state_d;
  logic [IW-1:0]      grant_q, grant_d, rr_ptr_q, rr_ptr_d;
  logic [7:0]         addr_q, addr_d, addr_sel;
  logic [15:0]        data_q, data_d, data_sel;
  logic [15:0]        gap_q, gap_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_vld_q, tx_vld_d;
  logic [31:0]        frame_num_q, frame_num_d;
  logic               xfer, frame_done;
  logic [NUM_REQ-1:0] arb_oh;
  logic [IW-1:0]      arb_idx;
  logic               arb_vld;

  uart_rr_arb #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  always_comb begin
    addr_sel = '0;
    data_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_oh[i]) begin
        addr_sel = req_addr[8*i +: 8];
        data_sel = req_data[16*i +: 16];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    gap_d      = gap_q;
    ack_d      = '0;
    frame_done = 1'b0;
    xfer       = tx_vld_q && tx_rdy;
    case (state_q)
      S_IDLE: if (arb_vld) begin
        state_d  = S_HDR0;
        grant_d  = arb_idx;
        addr_d   = addr_sel;
        data_d   = data_sel;
        rr_ptr_d = (arb_idx == LAST) ? '0 : arb_idx + IW'(1);
      end
      S_HDR0:  if (xfer) state_d = S_HDR1;
      S_HDR1:  if (xfer) state_d = S_ADDR;
      S_ADDR:  if (xfer) state_d = S_DATAL;
      S_DATAL: if (xfer) state_d = S_DATAH;
      S_DATAH: if (xfer) begin
        state_d    = S_GAP;
        frame_done = 1'b1;
        gap_d      = (GAP_CYCLES == 16'd0) ? 16'd0 : GAP_CYCLES - 16'd1;
        for (int i = 0; i < NUM_REQ; i++) ack_d[i] = (IW'(i) == grant_q);
      end
      S_GAP: begin
        if (gap_q == 16'd0) state_d = S_IDLE;
        else                gap_d   = gap_q - 16'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Output byte is registered from the next state so it appears together
    // with the state it belongs to.
    tx_vld_d  = 1'b1;
    tx_data_d = 8'h00;
    case (state_d)
      S_HDR0:  tx_data_d = HDR0;
      S_HDR1:  tx_data_d = HDR1;
      S_ADDR:  tx_data_d = addr_d;
      S_DATAL: tx_data_d = data_d[7:0];
      S_DATAH: tx_data_d = data_d[15:8];
      default: tx_vld_d  = 1'b0;
    endcase

    if (reg_frame_clr)   frame_num_d = 32'd0;
    else if (frame_done) frame_num_d = frame_num_q + 32'd1;
    else                 frame_num_d = frame_num_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      gap_q       <= '0;
      ack_q       <= '0;
      tx_data_q   <= '0;
      tx_vld_q    <= 1'b0;
      frame_num_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      gap_q       <= gap_d;
      ack_q       <= ack_d;
      tx_data_q   <= tx_data_d;
      tx_vld_q    <= tx_vld_d;
      frame_num_q <= frame_num_d;
    end
  end

  assign ack           = ack_q;
  assign tx_data       = tx_data_q;
  assign tx_vld        = tx_vld_q;
  assign busy          = (state_q != S_IDLE);
  assign reg_frame_num = frame_num_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_uart_cmd_sched.sv
// Directed bench for uart_cmd_sched: byte scoreboard on the tx handshake,
// hold checks under backpressure, and per-scenario ack/counter checks.
module tb_uart_cmd_sched;
  import uart_pkg::*;

  localparam int          NUM_REQ = 2;
  localparam logic [15:0] GAP     = 16'd4;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [15:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  ack;
  logic [7:0]  tx_data;
  logic        tx_vld;
  logic        tx_rdy;
  logic        busy;
  logic [31:0] reg_frame_num;
  logic        reg_frame_clr;
  logic [7:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic bp_mode = 1'b0;
  logic [7:0] exp_q[$];

  uart_cmd_sched #(.NUM_REQ(NUM_REQ), .GAP_CYCLES(GAP)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .ack           (ack),
    .tx_data       (tx_data),
    .tx_vld        (tx_vld),
    .tx_rdy        (tx_rdy),
    .busy          (busy),
    .reg_frame_num (reg_frame_num),
    .reg_frame_clr (reg_frame_clr),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bp_mode) tx_rdy = (cyc % 3 == 0);
  endtask

  task automatic push_frame(input logic [7:0] a, input logic [15:0] d);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hAA);
    exp_q.push_back(a);
    exp_q.push_back(d[7:0]);
    exp_q.push_back(d[15:8]);
  endtask

  task automatic wait_ack(output logic [1:0] a, output int lat, output int gaps);
    lat  = 0;
    gaps = 0;
    do begin
      if (dbg_state == S_GAP) gaps++;
      tick();
      lat++;
    end while (ack == 2'b00 && lat < 60);
    a = ack;
  endtask

  task automatic wait_idle(output int gaps, output int acks);
    int n;
    n    = 0;
    gaps = 0;
    acks = 0;
    while (busy && n < 100) begin
      if (dbg_state == S_GAP) gaps++;
      tick();
      n++;
      if (ack != 2'b00) acks++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  // scoreboard: every accepted byte must match the head of exp_q
  always @(posedge clk) begin
    if (rst_n && tx_vld && tx_rdy) begin
      if (exp_q.size() == 0) chk("exp_q_nonempty", 32'(exp_q.size()), 32'd1);
      else                   chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
    end
  end

  // a stalled byte must stay valid and unchanged on the next cycle
  logic       prev_stall;
  logic [7:0] prev_data;
  always @(posedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_vld", 32'(tx_vld), 32'd1);
        chk("hold_data", 32'(tx_data), 32'(prev_data));
      end
      prev_stall <= tx_vld && !tx_rdy;
      prev_data  <= tx_data;
    end
  end

  initial begin
    logic [1:0] a;
    int lat, gaps, acks;
    logic [1:0] fair_exp [4];

    rst_n = 1'b0; req = '0; req_addr = '0; req_data = '0;
    tx_rdy = 1'b1; reg_frame_clr = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_tx_vld", 32'(tx_vld), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_num", reg_frame_num, 32'd0);

    // single unlock frame, tx_rdy held high
    req_addr[7:0] = REG_UNLOCK; req_data[15:0] = UNLOCK_KEY;
    push_frame(REG_UNLOCK, UNLOCK_KEY);
    req = 2'b01;
    tick();
    chk("first_vld", 32'(tx_vld), 32'd1);
    chk("first_byte", 32'(tx_data), 32'hFF);
    wait_ack(a, lat, gaps);
    chk("single_ack", 32'(a), 32'h1);
    chk("single_latency", 32'(lat), 32'd5);
    req = 2'b00;
    chk("single_frame_num", reg_frame_num, 32'd1);
    chk("gap_busy", 32'(busy), 32'd1);
    wait_idle(gaps, acks);
    chk("single_gap", 32'(gaps), 32'(GAP));
    chk("single_ack_once", 32'(acks), 32'd0);

    // same frame under 1-in-3 backpressure
    push_frame(REG_UNLOCK, UNLOCK_KEY);
    bp_mode = 1'b1;
    req = 2'b01;
    wait_ack(a, lat, gaps);
    chk("bp_ack", 32'(a), 32'h1);
    req = 2'b00;
    wait_idle(gaps, acks);
    chk("bp_ack_once", 32'(acks), 32'd0);
    chk("bp_frame_num", reg_frame_num, 32'd2);
    bp_mode = 1'b0;
    tx_rdy = 1'b1;

    // reset during the address byte
    req_addr[7:0] = REG_CALSW; req_data[15:0] = 16'h0001;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hAA);
    req = 2'b01;
    tick(); tick(); tick();
    chk("pre_rst_state", 32'(dbg_state), 32'(S_ADDR));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(tx_vld), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_frame_num", reg_frame_num, 32'd0);
    chk("mid_rst_q_drained", 32'(exp_q.size()), 32'd0);
    req = 2'b10;
    req_addr[15:8] = REG_SAVE; req_data[31:16] = 16'h0001;
    tick();
    rst_n = 1'b1;
    push_frame(REG_SAVE, 16'h0001);
    tick();
    chk("post_rst_byte", 32'(tx_data), 32'hFF);
    wait_ack(a, lat, gaps);
    chk("post_rst_ack", 32'(a), 32'h2);
    req = 2'b00;
    wait_idle(gaps, acks);
    chk("post_rst_frame_num", reg_frame_num, 32'd1);

    // fairness with both requesters held
    req_addr = {REG_RRATE, REG_CALSW};
    req_data = {16'h0006, 16'h0004};
    fair_exp[0] = 2'b01; fair_exp[1] = 2'b10; fair_exp[2] = 2'b01; fair_exp[3] = 2'b10;
    for (int f = 0; f < 4; f++) begin
      if (fair_exp[f] == 2'b01) push_frame(REG_CALSW, 16'h0004);
      else                      push_frame(REG_RRATE, 16'h0006);
    end
    req = 2'b11;
    for (int f = 0; f < 4; f++) begin
      wait_ack(a, lat, gaps);
      chk("fair_ack", 32'(a), 32'(fair_exp[f]));
      if (f > 0) chk("fair_gap", 32'(gaps), 32'(GAP));
    end
    req = 2'b00;
    wait_idle(gaps, acks);
    chk("fair_frame_num", reg_frame_num, 32'd5);

    // inputs changed after grant must not leak into the frame
    req_addr[7:0] = REG_RRATE; req_data[15:0] = 16'h1234;
    push_frame(REG_RRATE, 16'h1234);
    req = 2'b01;
    tick(); tick();
    chk("latch_state", 32'(dbg_state), 32'(S_HDR1));
    req_data[15:0] = 16'hFFFF;
    req_addr[7:0]  = 8'h55;
    req = 2'b00;
    wait_ack(a, lat, gaps);
    chk("latch_ack", 32'(a), 32'h1);
    wait_idle(gaps, acks);
    chk("latch_frame_num", reg_frame_num, 32'd6);

    // clear on the completing edge wins
    push_frame(8'h55, 16'hFFFF);
    req = 2'b01;
    lat = 0;
    while (dbg_state != S_DATAH && lat < 20) begin tick(); lat++; end
    chk("clr_reach_datah", 32'(dbg_state), 32'(S_DATAH));
    reg_frame_clr = 1'b1;
    tick();
    reg_frame_clr = 1'b0;
    chk("clr_ack", 32'(ack), 32'h1);
    chk("clr_frame_num", reg_frame_num, 32'd0);
    req = 2'b00;
    wait_idle(gaps, acks);
    push_frame(8'h55, 16'hFFFF);
    req = 2'b01;
    wait_ack(a, lat, gaps);
    chk("after_clr_ack", 32'(a), 32'h1);
    req = 2'b00;
    chk("after_clr_frame_num", reg_frame_num, 32'd1);
    wait_idle(gaps, acks);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
